// File: rtl/mlp_pkg.sv
// mlp_pkg: types and constants shared by the mlp inference datapath and its
// classifier head.
//   DATA_WIDTH_DEF : default logit width (signed Q8.8)
//   VEC_DEF        : default lanes per output BRAM word
//   FRAC_BITS      : fractional bits of the Q8.8 format
//   argmax_state_t : state encoding of the mlp_argmax controller
package mlp_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int VEC_DEF        = 16;
    localparam int FRAC_BITS      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } argmax_state_t;

endpackage

// File: rtl/mlp_argmax.sv
// mlp_argmax: classifier head. On start, reads the layer-3 output BRAM one
// word at a time and scans the first DEPTH signed logits, one lane per cycle,
// reporting the index and value of the largest one (lowest index on ties).
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : one-cycle request, honoured only in IDLE
//   bram_en      : BRAM read enable (high in FETCH)
//   bram_addr    : BRAM word address
//   bram_rdata   : BRAM read data, valid one cycle after bram_en
//   busy         : run in progress (FETCH..DONE)
//   done         : one-cycle pulse, result final
//   valid        : class_out/max_out hold a completed result
//   class_out    : argmax index
//   max_out      : logit at class_out
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; results held
// FETCH | bram_en high, bram_addr = current word
// WAIT  | BRAM data arriving; captured into word_q
// SCAN  | one lane compared per cycle
// DONE  | done pulse; results visible together with it
module mlp_argmax
    import mlp_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int VEC        = VEC_DEF,
    parameter  int DEPTH      = 10,
    localparam int WORDS      = (DEPTH + VEC - 1) / VEC,
    localparam int CLASS_W    = $clog2(DEPTH),
    localparam int ADDR_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      bram_en,
    output logic [ADDR_W-1:0]         bram_addr,
    input  logic [VEC*DATA_WIDTH-1:0] bram_rdata,
    output logic                      busy,
    output logic                      done,
    output logic                      valid,
    output logic [CLASS_W-1:0]        class_out,
    output logic [DATA_WIDTH-1:0]     max_out
);

    localparam int LANE_W = (VEC > 1) ? $clog2(VEC) : 1;

    argmax_state_t                state;
    logic [VEC*DATA_WIDTH-1:0]    word_q;
    logic [LANE_W-1:0]            lane_ptr;
    logic [CLASS_W-1:0]           idx_cnt;    // global index word*VEC + lane
    logic signed [DATA_WIDTH-1:0] best;
    logic [CLASS_W-1:0]           best_idx;

    logic signed [DATA_WIDTH-1:0] lane_val;
    logic                         take;
    logic signed [DATA_WIDTH-1:0] next_best;
    logic [CLASS_W-1:0]           next_idx;
    logic                         last_global;
    logic                         last_lane;

    // Running best including the lane under inspection, so the final lane's
    // outcome can be published on entry to DONE.
    always_comb begin
        lane_val    = $signed(word_q[lane_ptr*DATA_WIDTH +: DATA_WIDTH]);
        take        = (idx_cnt == '0) || (lane_val > best);
        next_best   = take ? lane_val : best;
        next_idx    = take ? idx_cnt  : best_idx;
        last_global = (idx_cnt == CLASS_W'(DEPTH - 1));
        last_lane   = (lane_ptr == LANE_W'(VEC - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            class_out <= '0;
            max_out   <= '0;
            word_q    <= '0;
            lane_ptr  <= '0;
            idx_cnt   <= '0;
            best      <= '0;
            best_idx  <= '0;
        end else begin
            bram_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bram_addr <= '0;
                        lane_ptr  <= '0;
                        idx_cnt   <= '0;
                        valid     <= 1'b0;
                        busy      <= 1'b1;
                        bram_en   <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    word_q <= bram_rdata;
                    state  <= ST_SCAN;
                end
                ST_SCAN: begin
                    best     <= next_best;
                    best_idx <= next_idx;
                    idx_cnt  <= idx_cnt + 1'b1;
                    lane_ptr <= lane_ptr + 1'b1;
                    if (last_global) begin
                        class_out <= next_idx;
                        max_out   <= next_best;
                        valid     <= 1'b1;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else if (last_lane) begin
                        lane_ptr  <= '0;
                        bram_addr <= bram_addr + 1'b1;
                        bram_en   <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_argmax.sv
// tb_mlp_argmax: directed bench for mlp_argmax. Instance a uses DEPTH=10
// (one BRAM word), instance b uses DEPTH=20 (two words). Each has a small
// BRAM model returning the addressed word one cycle after bram_en and a
// 0x7FFF-filled word in every other cycle.
module tb_mlp_argmax;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance a: DEPTH=10 -> CLASS_W=4, ADDR_W=1
    logic         start_a = 1'b0;
    logic         en_a;
    logic [0:0]   addr_a;
    logic [255:0] rdata_a;
    logic         busy_a, done_a, valid_a;
    logic [3:0]   class_a;
    logic [15:0]  max_a;
    logic [255:0] mem_a [2];

    // instance b: DEPTH=20 -> CLASS_W=5, ADDR_W=1
    logic         start_b = 1'b0;
    logic         en_b;
    logic [0:0]   addr_b;
    logic [255:0] rdata_b;
    logic         busy_b, done_b, valid_b;
    logic [4:0]   class_b;
    logic [15:0]  max_b;
    logic [255:0] mem_b [2];

    mlp_argmax #(.DATA_WIDTH(16), .VEC(16), .DEPTH(10)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bram_en(en_a), .bram_addr(addr_a),
        .bram_rdata(rdata_a), .busy(busy_a), .done(done_a), .valid(valid_a),
        .class_out(class_a), .max_out(max_a)
    );

    mlp_argmax #(.DATA_WIDTH(16), .VEC(16), .DEPTH(20)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bram_en(en_b), .bram_addr(addr_b),
        .bram_rdata(rdata_b), .busy(busy_b), .done(done_b), .valid(valid_b),
        .class_out(class_b), .max_out(max_b)
    );

    always @(posedge clk) begin
        rdata_a <= en_a ? mem_a[addr_a] : {16{16'h7FFF}};
        rdata_b <= en_b ? mem_b[addr_b] : {16{16'h7FFF}};
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] vec [16];

    task automatic load_a();
        for (int k = 0; k < 16; k++) mem_a[0][k*16 +: 16] = vec[k];
        mem_a[1] = '0;
    endtask

    task automatic load_b(input int w);
        for (int k = 0; k < 16; k++) mem_b[w][k*16 +: 16] = vec[k];
    endtask

    task automatic set_basic();
        vec = '{16'h0100, 16'hFF00, 16'h0300, 16'h0280, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0050, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    endtask

    task automatic set_ties();
        vec = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0100, 16'h0100, 16'h0200,
                16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    endtask

    // Pulses start_a for one cycle (cycle 0) and watches up to 40 cycles.
    // Returns at the negedge of the done cycle, or after the budget with done_cyc=-1.
    task automatic go_a(output int done_cyc, output int en_cnt, output int en_cyc0,
                        output logic [0:0] en_addr0, output logic busy1, output logic valid1);
        done_cyc = -1; en_cnt = 0; en_cyc0 = -1; en_addr0 = 1'b1; busy1 = 1'b0; valid1 = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) begin busy1 = busy_a; valid1 = valid_a; end
            if (en_a) begin
                en_cnt++;
                if (en_cyc0 < 0) begin en_cyc0 = k; en_addr0 = addr_a; end
            end
            if (done_a) begin done_cyc = k; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total_cnt += 7;
        if (en_a !== 1'b0)      $display("FAIL reset_bram_en got %b want 0", en_a);     else pass_cnt++;
        if (addr_a !== 1'b0)    $display("FAIL reset_bram_addr got %h want 0", addr_a); else pass_cnt++;
        if (busy_a !== 1'b0)    $display("FAIL reset_busy got %b want 0", busy_a);      else pass_cnt++;
        if (done_a !== 1'b0)    $display("FAIL reset_done got %b want 0", done_a);      else pass_cnt++;
        if (valid_a !== 1'b0)   $display("FAIL reset_valid got %b want 0", valid_a);    else pass_cnt++;
        if (class_a !== 4'd0)   $display("FAIL reset_class got %0d want 0", class_a);   else pass_cnt++;
        if (max_a !== 16'h0000) $display("FAIL reset_max got %h want 0000", max_a);     else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dc, ec, e0; logic [0:0] a0; logic b1, v1;
        set_basic(); load_a();
        go_a(dc, ec, e0, a0, b1, v1);
        total_cnt += 11;
        if (dc !== 13)          $display("FAIL basic_done_cycle got %0d want 13", dc);  else pass_cnt++;
        if (class_a !== 4'd2)   $display("FAIL basic_class got %0d want 2", class_a);   else pass_cnt++;
        if (max_a !== 16'h0300) $display("FAIL basic_max got %h want 0300", max_a);     else pass_cnt++;
        if (valid_a !== 1'b1)   $display("FAIL basic_valid got %b want 1", valid_a);    else pass_cnt++;
        if (ec !== 1)           $display("FAIL basic_en_count got %0d want 1", ec);     else pass_cnt++;
        if (e0 !== 1)           $display("FAIL basic_en_cycle got %0d want 1", e0);     else pass_cnt++;
        if (a0 !== 1'b0)        $display("FAIL basic_en_addr got %h want 0", a0);       else pass_cnt++;
        if (b1 !== 1'b1)        $display("FAIL basic_busy_c1 got %b want 1", b1);       else pass_cnt++;
        if (busy_a !== 1'b1)    $display("FAIL basic_busy_done got %b want 1", busy_a); else pass_cnt++;
        @(negedge clk);
        if (done_a !== 1'b0)    $display("FAIL basic_done_pulse got %b want 0", done_a); else pass_cnt++;
        if (busy_a !== 1'b0)    $display("FAIL basic_busy_idle got %b want 0", busy_a);  else pass_cnt++;
    endtask

    task automatic test_negative();
        int dc, ec, e0; logic [0:0] a0; logic b1, v1;
        vec = '{16'hFF00, 16'hFE00, 16'h8000, 16'hFF00, 16'hC000, 16'hFF00, 16'hFE80, 16'h8001,
                16'hF000, 16'hFFF0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        load_a();
        go_a(dc, ec, e0, a0, b1, v1);
        total_cnt += 4;
        if (dc !== 13)          $display("FAIL neg_done_cycle got %0d want 13", dc);     else pass_cnt++;
        if (class_a !== 4'd9)   $display("FAIL neg_class got %0d want 9", class_a);      else pass_cnt++;
        if (max_a !== 16'hFFF0) $display("FAIL neg_max got %h want fff0", max_a);        else pass_cnt++;
        if (v1 !== 1'b0)        $display("FAIL neg_valid_cleared got %b want 0", v1);    else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_ties();
        int dc, ec, e0; logic [0:0] a0; logic b1, v1;
        set_ties(); load_a();
        go_a(dc, ec, e0, a0, b1, v1);
        total_cnt += 2;
        if (class_a !== 4'd4)   $display("FAIL ties_class got %0d want 4", class_a);  else pass_cnt++;
        if (max_a !== 16'h0200) $display("FAIL ties_max got %h want 0200", max_a);    else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_two_words();
        int dc, ec;
        int ecyc [2];
        logic [0:0] eaddr [2];
        vec = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0300, 16'h0100, 16'h0100,
                16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
        load_b(0);
        vec = '{16'h0200, 16'h0400, 16'h0380, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        load_b(1);
        dc = -1; ec = 0; ecyc = '{-1, -1}; eaddr = '{1'b1, 1'b0};
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (en_b) begin
                if (ec < 2) begin ecyc[ec] = k; eaddr[ec] = addr_b; end
                ec++;
            end
            if (done_b) begin dc = k; break; end
        end
        total_cnt += 8;
        if (dc !== 25)          $display("FAIL two_done_cycle got %0d want 25", dc);    else pass_cnt++;
        if (class_b !== 5'd17)  $display("FAIL two_class got %0d want 17", class_b);    else pass_cnt++;
        if (max_b !== 16'h0400) $display("FAIL two_max got %h want 0400", max_b);       else pass_cnt++;
        if (ec !== 2)           $display("FAIL two_en_count got %0d want 2", ec);       else pass_cnt++;
        if (ecyc[0] !== 1)      $display("FAIL two_en0_cycle got %0d want 1", ecyc[0]); else pass_cnt++;
        if (eaddr[0] !== 1'b0)  $display("FAIL two_en0_addr got %h want 0", eaddr[0]);  else pass_cnt++;
        if (ecyc[1] !== 19)     $display("FAIL two_en1_cycle got %0d want 19", ecyc[1]); else pass_cnt++;
        if (eaddr[1] !== 1'b1)  $display("FAIL two_en1_addr got %h want 1", eaddr[1]);  else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int dc, ec, e0, nd; logic [0:0] a0; logic b1, v1;
        set_basic(); load_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (5) @(negedge clk);   // cycle 6: in SCAN
        rst = 1'b1;
        #1;
        total_cnt += 5;
        if (busy_a !== 1'b0)    $display("FAIL rstmid_busy got %b want 0", busy_a);     else pass_cnt++;
        if (valid_a !== 1'b0)   $display("FAIL rstmid_valid got %b want 0", valid_a);   else pass_cnt++;
        if (class_a !== 4'd0)   $display("FAIL rstmid_class got %0d want 0", class_a);  else pass_cnt++;
        if (max_a !== 16'h0000) $display("FAIL rstmid_max got %h want 0000", max_a);    else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        if (nd !== 0)           $display("FAIL rstmid_no_done got %0d want 0", nd);     else pass_cnt++;
        go_a(dc, ec, e0, a0, b1, v1);
        total_cnt += 3;
        if (dc !== 13)          $display("FAIL rstmid_rerun_cycle got %0d want 13", dc); else pass_cnt++;
        if (class_a !== 4'd2)   $display("FAIL rstmid_rerun_class got %0d want 2", class_a); else pass_cnt++;
        if (max_a !== 16'h0300) $display("FAIL rstmid_rerun_max got %h want 0300", max_a); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int nd;
        int dcyc [2];
        logic [3:0] dcls [2];
        logic [15:0] dmax [2];
        logic v14, v15;
        set_basic(); load_a();
        nd = 0; dcyc = '{-1, -1}; dcls = '{4'hF, 4'hF}; dmax = '{16'hDEAD, 16'hDEAD};
        v14 = 1'b0; v15 = 1'b1;
        @(negedge clk); start_a = 1'b1;   // high for cycles 0..19
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 5) begin set_ties(); load_a(); end
            if (k == 20) start_a = 1'b0;
            if (k == 14) v14 = valid_a;
            if (k == 15) v15 = valid_a;
            if (done_a) begin
                if (nd < 2) begin dcyc[nd] = k; dcls[nd] = class_a; dmax[nd] = max_a; end
                nd++;
            end
        end
        total_cnt += 9;
        if (nd !== 2)           $display("FAIL b2b_done_count got %0d want 2", nd);      else pass_cnt++;
        if (dcyc[0] !== 13)     $display("FAIL b2b_done0_cycle got %0d want 13", dcyc[0]); else pass_cnt++;
        if (dcyc[1] !== 27)     $display("FAIL b2b_done1_cycle got %0d want 27", dcyc[1]); else pass_cnt++;
        if (dcls[0] !== 4'd2)   $display("FAIL b2b_class0 got %0d want 2", dcls[0]);     else pass_cnt++;
        if (dmax[0] !== 16'h0300) $display("FAIL b2b_max0 got %h want 0300", dmax[0]);   else pass_cnt++;
        if (dcls[1] !== 4'd4)   $display("FAIL b2b_class1 got %0d want 4", dcls[1]);     else pass_cnt++;
        if (dmax[1] !== 16'h0200) $display("FAIL b2b_max1 got %h want 0200", dmax[1]);   else pass_cnt++;
        if (v14 !== 1'b1)       $display("FAIL b2b_valid_c14 got %b want 1", v14);       else pass_cnt++;
        if (v15 !== 1'b0)       $display("FAIL b2b_valid_c15 got %b want 0", v15);       else pass_cnt++;
    endtask

    initial begin
        mem_a[0] = '0; mem_a[1] = '0;
        mem_b[0] = '0; mem_b[1] = '0;
        test_reset();
        test_basic();
        test_negative();
        test_ties();
        test_two_words();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
